jtdsp16_ram: RTL and testbench

- Internal data RAM stage of the DSP16 core, directly downstream of the YAAU.
- Consumes the YAAU's 11-bit `ram_addr` and returns `ram_dout`, which the YAAU uses for register loads.
- Serves plain reads, plain writes and two-cycle compound read-then-write (swap) accesses.
- During the write half of a compound access it raises `stall` so the sequencer freezes the YAAU post-modify.

---
 rtl/jtdsp16_ram_pkg.sv | 14 +
 rtl/jtdsp16_ram_1p.sv | 30 +++
 rtl/jtdsp16_ram.sv | 89 ++++++++
 tb/tb_jtdsp16_ram.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_ram_pkg.sv
// rtl/jtdsp16_ram_pkg.sv - shared widths and FSM encodings for the DSP16 data RAM stage
// Purpose: default address/data widths (also used by the YAAU) and the
//          controller state encodings.
// Ports:   none (package).
package jtdsp16_ram_pkg;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 16;

  // One-bit state: IDLE accepts requests, CMP_WR finishes a compound swap.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_CMP_WR = 1'b1;

endpackage

// File: rtl/jtdsp16_ram_1p.sv
// rtl/jtdsp16_ram_1p.sv - generic single-port RAM, synchronous write, read-first
// Purpose: word-addressed storage; the read port is unregistered so the
//          owner supplies the output register (read-first falls out of it).
// Ports:   clk_i   - clock
//          addr_i  - word address
//          we_i    - write strobe (already qualified by the clock enable)
//          wdata_i - write data
//          rdata_o - contents at addr_i before any write on this edge
module jtdsp16_ram_1p #(
  parameter int AW      = 11,
  parameter int DW      = 16,
  parameter     SIMFILE = ""
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  // SIMFILE names an optional simulation image; contents are never reset.
  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/jtdsp16_ram.sv
// rtl/jtdsp16_ram.sv - DSP16 internal data RAM controller with compound swap
// Purpose: plain read, plain write and two-cycle read-then-write accesses
//          for the YAAU address stream.
// Ports:   clk, rst (async, active high), cen (clock enable)
//          ram_addr, rd_en, wr_en, compound, din - request from YAAU/DAU
//          ram_dout  - registered read data
//          stall     - write half of a compound pending
//          busy_addr - address latched by the compound read half
import jtdsp16_ram_pkg::*;

module jtdsp16_ram #(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter     SIMFILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] ram_addr,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic          compound,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] ram_dout,
  output logic          stall,
  output logic [AW-1:0] busy_addr
);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] busy_addr_q, busy_addr_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  always_comb begin
    state_d     = state_q;
    busy_addr_d = busy_addr_q;
    dout_d      = dout_q;
    mem_addr    = ram_addr;
    mem_we      = 1'b0;
    if (state_q == ST_CMP_WR) begin
      // Second half of a swap: all request inputs ignored, write lands at
      // the latched address. An async reset here drops the write.
      mem_addr = busy_addr_q;
      mem_we   = cen;
      if (cen) state_d = ST_IDLE;
    end else if (cen) begin
      if (compound) begin
        dout_d      = mem_rdata;
        busy_addr_d = ram_addr;
        state_d     = ST_CMP_WR;
      end else begin
        if (rd_en) dout_d = mem_rdata;
        mem_we = wr_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_addr_q <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_addr_q <= busy_addr_d;
      dout_q      <= dout_d;
    end
  end

  jtdsp16_ram_1p #(
    .AW      (AW),
    .DW      (DW),
    .SIMFILE (SIMFILE)
  ) u_mem (
    .clk_i   (clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .wdata_i (din),
    .rdata_o (mem_rdata)
  );

  assign stall     = (state_q == ST_CMP_WR);
  assign ram_dout  = dout_q;
  assign busy_addr = busy_addr_q;

endmodule

// File: tb/tb_jtdsp16_ram.sv
// tb/tb_jtdsp16_ram.sv - self-checking bench for jtdsp16_ram
module tb_jtdsp16_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [10:0] ram_addr;
  logic        rd_en;
  logic        wr_en;
  logic        compound;
  logic [15:0] din;
  logic [15:0] ram_dout;
  logic        stall;
  logic [10:0] busy_addr;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  jtdsp16_ram dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .ram_addr  (ram_addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .compound  (compound),
    .din       (din),
    .ram_dout  (ram_dout),
    .stall     (stall),
    .busy_addr (busy_addr)
  );

  always #5 clk = ~clk;

  // Reference model: an array of words, the last value read, and whether a
  // swap write is owed to a remembered address.
  logic [15:0] m_mem [0:2047];
  logic [15:0] m_dout;
  logic        m_pend;
  logic [10:0] m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dout = 16'h0000;
      m_pend = 1'b0;
      m_busy = 11'h000;
    end else if (cen) begin
      if (m_pend) begin
        m_mem[m_busy] = din;
        m_pend = 1'b0;
      end else if (compound) begin
        m_dout = m_mem[ram_addr];
        m_busy = ram_addr;
        m_pend = 1'b1;
      end else begin
        if (rd_en) m_dout = m_mem[ram_addr];
        if (wr_en) m_mem[ram_addr] = din;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_dout", {16'h0, ram_dout}, {16'h0, m_dout});
      chk("model_stall", {31'h0, stall}, {31'h0, m_pend});
      chk("model_busy", {21'h0, busy_addr}, {21'h0, m_busy});
    end
  end

  // Drive one request, let the clock edge take it, sample 1 unit later.
  task automatic step(input logic c, input logic [10:0] a, input logic r,
                      input logic w, input logic cp, input logic [15:0] d);
    cen = c; ram_addr = a; rd_en = r; wr_en = w; compound = cp; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) m_mem[i] = 16'h0000;
    rst = 1'b1; cen = 1'b0; ram_addr = '0; rd_en = 1'b0; wr_en = 1'b0;
    compound = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", {16'h0, ram_dout}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_busy", {21'h0, busy_addr}, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Unloaded memory reads as zero
    step(1, 11'h000, 1, 0, 0, 16'h0);
    chk("read0_dout", {16'h0, ram_dout}, 32'h0000);
    chk("read0_stall", {31'h0, stall}, 32'h0);

    // Top address write then read; write leaves ram_dout alone
    step(1, 11'h7FF, 0, 1, 0, 16'h1234);
    chk("wr_no_dout", {16'h0, ram_dout}, 32'h0000);
    step(1, 11'h7FF, 1, 0, 0, 16'h0);
    chk("read7ff", {16'h0, ram_dout}, 32'h1234);

    // Same-cycle read/write is read-first
    step(1, 11'h010, 0, 1, 0, 16'hAAAA);
    step(1, 11'h010, 1, 1, 0, 16'h5555);
    chk("rw_old", {16'h0, ram_dout}, 32'hAAAA);
    step(1, 11'h010, 1, 0, 0, 16'h0);
    chk("rw_new", {16'h0, ram_dout}, 32'h5555);

    // Compound: address and requests change during CMP_WR and must be ignored
    step(1, 11'h020, 0, 1, 0, 16'h00FF);
    step(1, 11'h020, 0, 0, 1, 16'h0);
    chk("cmp_dout", {16'h0, ram_dout}, 32'h00FF);
    chk("cmp_stall", {31'h0, stall}, 32'h1);
    chk("cmp_busy", {21'h0, busy_addr}, 32'h020);
    step(1, 11'h021, 1, 1, 1, 16'hFF00);
    chk("cmp_stall_drop", {31'h0, stall}, 32'h0);
    chk("cmp_dout_hold", {16'h0, ram_dout}, 32'h00FF);
    step(1, 11'h020, 1, 0, 0, 16'h0);
    chk("cmp_mem020", {16'h0, ram_dout}, 32'hFF00);
    step(1, 11'h021, 1, 0, 0, 16'h0);
    chk("cmp_mem021", {16'h0, ram_dout}, 32'h0000);

    // Compound with cen 1,0,0,1
    step(1, 11'h040, 0, 0, 1, 16'h0);
    chk("cen_stall1", {31'h0, stall}, 32'h1);
    step(0, 11'h041, 1, 1, 1, 16'h9999);
    chk("cen_stall2", {31'h0, stall}, 32'h1);
    step(0, 11'h042, 0, 1, 0, 16'h8888);
    chk("cen_stall3", {31'h0, stall}, 32'h1);
    step(1, 11'h043, 0, 0, 0, 16'h4242);
    chk("cen_stall4", {31'h0, stall}, 32'h0);
    step(1, 11'h040, 1, 0, 0, 16'h0);
    chk("cen_mem040", {16'h0, ram_dout}, 32'h4242);
    step(1, 11'h041, 1, 0, 0, 16'h0);
    chk("cen_mem041", {16'h0, ram_dout}, 32'h0000);

    // Back-to-back compounds
    step(1, 11'h050, 0, 0, 1, 16'h0);
    step(1, 11'h000, 0, 0, 0, 16'hBEEF);
    step(1, 11'h050, 0, 0, 1, 16'h0);
    chk("b2b_dout", {16'h0, ram_dout}, 32'hBEEF);
    step(1, 11'h000, 0, 0, 0, 16'hCAFE);
    step(1, 11'h050, 1, 0, 0, 16'h0);
    chk("b2b_final", {16'h0, ram_dout}, 32'hCAFE);

    // Reset during CMP_WR discards the pending write
    step(1, 11'h030, 0, 1, 0, 16'h1111);
    step(1, 11'h030, 0, 0, 1, 16'h0);
    chk("rst_pre_stall", {31'h0, stall}, 32'h1);
    din = 16'h2222; compound = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_stall", {31'h0, stall}, 32'h0);
    chk("rst_async_dout", {16'h0, ram_dout}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 11'h030, 1, 0, 0, 16'h0);
    chk("rst_mem030", {16'h0, ram_dout}, 32'h1111);

    step(0, 11'h000, 0, 0, 0, 16'h0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
